dmem_responder: RTL and testbench

Responder end of the pipeline's data-memory port: accepts one load/store request at a time over a valid/ready handshake, holds it for a configurable access latency, then returns a one-cycle response. It replaces the zero-latency data memory behind the MEM stage, so the core has to stall on `req_ready_o` and `resp_valid_o`. Two fixed words are exported continuously as `out1_o` / `out2_o` for the existing result-observation taps.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 52 +++++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DMEM_WORD_W = 32;
  localparam int unsigned DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

  // One captured load/store request.
  typedef struct packed {
    logic                   write;
    logic [DMEM_WORD_W-1:0] addr;
    logic [DMEM_WORD_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word store: one synchronous write port, one registered read
// port (cleared on reset or on a non-load response) and two asynchronous
// tap ports. Contents start at zero and are not touched by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned TAP1_IDX = 0,
  parameter int unsigned TAP2_IDX = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DMEM_WORD_W-1:0]     wdata,
  input  logic                       re,
  input  logic                       clr,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DMEM_WORD_W-1:0]     rdata,
  output logic [DMEM_WORD_W-1:0]     tap1,
  output logic [DMEM_WORD_W-1:0]     tap2
);

  localparam int unsigned AW = $clog2(DEPTH);
  // Tap indices wrap modulo DEPTH, same as request addresses.
  localparam logic [AW-1:0] TAP1 = AW'(TAP1_IDX);
  localparam logic [AW-1:0] TAP2 = AW'(TAP2_IDX);

  logic [DMEM_WORD_W-1:0] mem [DEPTH] = '{default: '0};

  // Write port; storage is never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read register holds the last load result until the next response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else if (clr) begin
      rdata <= '0;
    end
  end

  assign tap1 = mem[TAP1];
  assign tap2 = mem[TAP2];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store over valid/ready,
// answered LATENCY cycles after acceptance with a one-cycle strobe.
// Optional feature macro DMEM_RESP_ERR_EN: flag misaligned or out-of-range
// requests; otherwise addresses wrap modulo DEPTH and resp_err_o stays 0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned OUT1_IDX = 500,
  parameter int unsigned OUT2_IDX = 501
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_write_i,
  input  logic [DMEM_WORD_W-1:0] req_addr_i,
  input  logic [DMEM_WORD_W-1:0] req_wdata_i,
  output logic                   resp_valid_o,
  output logic [DMEM_WORD_W-1:0] resp_rdata_o,
  output logic                   resp_err_o,
  output logic [DMEM_WORD_W-1:0] out1_o,
  output logic [DMEM_WORD_W-1:0] out2_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = DMEM_IDLE;
  localparam logic [1:0] BUSY = DMEM_BUSY;
  localparam logic [1:0] RESP = DMEM_RESP;

`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic [1:0]            state, state_nxt;
  logic [DMEM_CNT_W-1:0] cnt, cnt_nxt;
  dmem_req_t             req_q, req_in, req_sel;
  logic                  accept, enter_resp, fault;
  logic                  do_write, do_read, do_clr;
  logic [AW-1:0]         idx;

  assign req_in      = {req_write_i, req_addr_i, req_wdata_i};
  assign req_ready_o = (state == IDLE) || (state == RESP);
  assign accept      = req_valid_i && req_ready_o;

  // With LATENCY == 1 the response edge is the accept edge, so use live inputs.
  assign req_sel = (state == BUSY) ? req_q : req_in;
  assign idx     = req_sel.addr[AW+1:2];
  assign fault   = ERR_EN && ((req_sel.addr[1:0] != 2'b00) ||
                              (req_sel.addr[31:2] >= 30'(DEPTH)));

  assign do_write = enter_resp && rst_ni && req_sel.write && !fault;
  assign do_read  = enter_resp && !req_sel.write && !fault;
  assign do_clr   = enter_resp && (req_sel.write || fault);

  // State and latency counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; enter_resp marks the edge that commits the access.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = DMEM_CNT_W'(LATENCY - 2);
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - DMEM_CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the accepted request for the BUSY period.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_q <= '0;
    end else if (accept) begin
      req_q <= req_in;
    end
  end

  // Response strobe and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
    end else begin
      resp_valid_o <= enter_resp;
      if (enter_resp) begin
        resp_err_o <= fault;
      end
    end
  end

  dmem_array #(
    .DEPTH   (DEPTH),
    .TAP1_IDX(OUT1_IDX),
    .TAP2_IDX(OUT2_IDX)
  ) u_array (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .we   (do_write),
    .waddr(idx),
    .wdata(req_sel.wdata),
    .re   (do_read),
    .clr  (do_clr),
    .raddr(idx),
    .rdata(resp_rdata_o),
    .tap1 (out1_o),
    .tap2 (out2_o)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 1) checked every
// cycle against a transaction-level memory model.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned T1    = 500 % DEPTH;
  localparam int unsigned T2    = 501 % DEPTH;
`ifdef DMEM_RESP_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
  } breq_t;

  logic        clk = 1'b0;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic [31:0] out1       [2];
  logic [31:0] out2       [2];

  int          lat [2] = '{2, 1};
  logic [31:0] mm  [2][DEPTH];
  logic [31:0] last_rd  [2];
  logic        last_err [2];
  breq_t       plan[$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_write_i(req_write[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]),
    .out1_o(out1[0]), .out2_o(out2[0])
  );

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_write_i(req_write[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]),
    .out1_o(out1[1]), .out2_o(out2[1])
  );

  // Reference address rules, expressed on the byte address.
  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % DEPTH;
  endfunction

  function automatic bit is_fault(input logic [31:0] a);
    return ERR_EN && (((a % 4) != 0) || ((a / 4) >= DEPTH));
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned w;
    logic [31:0] a;
    case ($urandom_range(0, 3))
      0:       w = 244;
      1:       w = 245;
      2:       w = $urandom_range(0, 7);
      default: w = $urandom_range(0, 1023);
    endcase
    a = w * 4;
    if ($urandom_range(0, 4) == 0) a = a + $urandom_range(1, 3);
    return a;
  endfunction

  task automatic add_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    breq_t r;
    r.wr = wr; r.addr = addr; r.wd = wd;
    plan.push_back(r);
  endtask

  // Play the queued plan into unit u and check every cycle against the model.
  task automatic run_plan(input int u, input bit gaps, input bit noise);
    int    cyc;
    int    due;
    bit    rdy;
    bit    ee;
    breq_t cur;
    cyc = 0; due = -1; cur = '0;
    while ((plan.size() > 0 || due >= cyc) && cyc < 3000) begin
      @(negedge clk);
      rdy = !(due > cyc);
      total++;
      if (req_ready[u] !== rdy) begin
        bad++; $display("FAIL ready u%0d cyc%0d: got %b want %b", u, cyc, req_ready[u], rdy);
      end
      total++;
      if (resp_valid[u] !== (due == cyc)) begin
        bad++; $display("FAIL resp_valid u%0d cyc%0d: got %b want %b", u, cyc, resp_valid[u], due == cyc);
      end
      if (due == cyc) begin
        ee = is_fault(cur.addr);
        if (cur.wr && !ee) mm[u][widx(cur.addr)] = cur.wd;
        last_rd[u]  = (cur.wr || ee) ? 32'h0 : mm[u][widx(cur.addr)];
        last_err[u] = ee;
        due = -1;
      end
      total++;
      if (resp_rdata[u] !== last_rd[u]) begin
        bad++; $display("FAIL rdata u%0d cyc%0d: got %h want %h", u, cyc, resp_rdata[u], last_rd[u]);
      end
      total++;
      if (resp_err[u] !== last_err[u]) begin
        bad++; $display("FAIL err u%0d cyc%0d: got %b want %b", u, cyc, resp_err[u], last_err[u]);
      end
      total++;
      if (out1[u] !== mm[u][T1] || out2[u] !== mm[u][T2]) begin
        bad++; $display("FAIL taps u%0d cyc%0d: got %h/%h want %h/%h", u, cyc, out1[u], out2[u], mm[u][T1], mm[u][T2]);
      end
      if (rdy && plan.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
        cur = plan.pop_front();
        req_valid[u] = 1'b1; req_write[u] = cur.wr;
        req_addr[u]  = cur.addr; req_wdata[u] = cur.wd;
        due = cyc + lat[u];
      end else begin
        req_valid[u] = noise && !rdy;
        req_write[u] = 1'($urandom_range(0, 1));
        req_addr[u]  = $urandom; req_wdata[u] = $urandom;
      end
      cyc++;
    end
    if (plan.size() > 0 || due >= cyc) begin
      total++; bad++;
      $display("FAIL timeout u%0d: %0d requests left, due=%0d", u, plan.size(), due);
      plan.delete();
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; req_valid[u] = 1'b0; req_write[u] = 1'b0;
      req_addr[u] = '0; req_wdata[u] = '0; last_rd[u] = '0; last_err[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      total++;
      if (resp_valid[u] !== 1'b0 || req_ready[u] !== 1'b1 || resp_rdata[u] !== 32'h0 ||
          resp_err[u] !== 1'b0 || out1[u] !== 32'h0 || out2[u] !== 32'h0) begin
        bad++;
        $display("FAIL reset u%0d: got v=%b r=%b d=%h e=%b o=%h/%h want 0 1 0 0 0/0",
                 u, resp_valid[u], req_ready[u], resp_rdata[u], resp_err[u], out1[u], out2[u]);
      end
      rst_n[u] = 1'b1;
    end
  endtask

  task automatic test_back_to_back();
    add_req(1'b1, 32'h7D0, 32'h0000_00AB);
    add_req(1'b0, 32'h7D0, 32'h0);
    add_req(1'b1, 32'h7D4, 32'h1234_5678);
    add_req(1'b0, 32'h7D4, 32'h0);
    run_plan(0, 1'b0, 1'b0);
  endtask

  task automatic test_lat1_stream();
    for (int i = 0; i < 4; i++) add_req(1'b1, 32'(i * 4 + 16), $urandom);
    for (int i = 0; i < 4; i++) add_req(1'b0, 32'(i * 4 + 16), 32'h0);
    add_req(1'b1, 32'h7D0, 32'hCAFE_0001);
    add_req(1'b0, 32'h7D0, 32'h0);
    run_plan(1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    total++;
    if (req_ready[0] !== 1'b1) begin
      bad++; $display("FAIL rst_mid_idle: ready got %b want 1", req_ready[0]);
    end
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 32'hC; req_wdata[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (req_ready[0] !== 1'b0) begin
      bad++; $display("FAIL rst_mid_busy: ready got %b want 0", req_ready[0]);
    end
    req_valid[0] = 1'b0; rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1; last_rd[0] = '0; last_err[0] = 1'b0;
    total++;
    if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || resp_rdata[0] !== 32'h0 || resp_err[0] !== 1'b0) begin
      bad++; $display("FAIL rst_mid_after: got v=%b r=%b d=%h e=%b want 0 1 0 0",
                      resp_valid[0], req_ready[0], resp_rdata[0], resp_err[0]);
    end
    @(negedge clk);
    total++;
    if (resp_valid[0] !== 1'b0) begin
      bad++; $display("FAIL rst_mid_noresp: resp_valid got %b want 0", resp_valid[0]);
    end
    add_req(1'b0, 32'hC, 32'h0);
    run_plan(0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_err();
    add_req(1'b1, 32'h400, 32'h5A5A_0400);
    add_req(1'b0, 32'h0, 32'h0);
    add_req(1'b0, 32'h2, 32'h0);
    add_req(1'b1, 32'h3, 32'h0BAD_0003);
    add_req(1'b0, 32'h0, 32'h0);
    run_plan(0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_noise();
    for (int i = 0; i < 12; i++) add_req(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    run_plan(0, 1'b0, 1'b1);
  endtask

  task automatic test_random(input int u);
    for (int i = 0; i < 40; i++) add_req(1'($urandom_range(0, 1)), rand_addr(), $urandom);
    run_plan(u, 1'b1, 1'b0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < int'(DEPTH); i++) mm[u][i] = '0;
    test_reset();
    test_back_to_back();
    test_lat1_stream();
    test_reset_mid_busy();
    test_wrap_err();
    test_busy_noise();
    test_random(0);
    test_random(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
